// File: rtl/btn_conditioner.sv
// Input conditioning for 4 push-buttons and 4 slide switches: 2-flop synchronizers,
// per-input debounce, button press pulses and the ball smash FSM.
// Define SMASH_COOLDOWN_EN to add a COOLDOWN lockout after every smash window.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SMASH_LEN       = 20000000,
  parameter int COOLDOWN_LEN    = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] usr_btn_raw,
  input  logic [3:0] usr_sw_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] sw_level,
  output logic       smash_active,
  output logic       smash_ready
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int SM_MAX = (SMASH_LEN > COOLDOWN_LEN) ? SMASH_LEN : COOLDOWN_LEN;
  localparam int SM_W   = $clog2(SM_MAX + 1);
  localparam logic [SM_W-1:0] SMASH_LOAD = SM_W'(SMASH_LEN - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
`ifdef SMASH_COOLDOWN_EN
  localparam logic [1:0] ST_COOLDOWN   = 2'd2;
  localparam logic [SM_W-1:0] COOLDOWN_LOAD = SM_W'(COOLDOWN_LEN - 1);
`endif

  // Bits [3:0] are the buttons, bits [7:4] the switches.
  logic [7:0]      sync_q1;
  logic [7:0]      sync_q2;
  logic [7:0]      stable;
  logic [7:0]      db_fire;
  logic [DB_W-1:0] db_cnt [8];

  logic [1:0]      state;
  logic [SM_W-1:0] smash_cnt;

  always_comb begin
    // NOTE: default assignment first so no path leaves db_fire unassigned (no latch).
    db_fire = '0;
    for (int i = 0; i < 8; i++) begin
      db_fire[i] = (sync_q2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {usr_sw_raw, usr_btn_raw};
      sync_q2 <= sync_q1;
    end
  end

  // NOTE: the counter array is ordinary flops, so it is reset like any other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable    <= '0;
      btn_press <= '0;
      for (int i = 0; i < 8; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if ((sync_q2[i] == stable[i]) || db_fire[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
      stable    <= stable ^ db_fire;
      // Pulse lands in the same cycle the new high level first appears.
      btn_press <= db_fire[3:0] & ~stable[3:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      smash_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (btn_press[3]) begin
            state     <= ST_ACTIVE;
            smash_cnt <= SMASH_LOAD;
          end
        end
        ST_ACTIVE: begin
          if (smash_cnt == '0) begin
`ifdef SMASH_COOLDOWN_EN
            state     <= ST_COOLDOWN;
            smash_cnt <= COOLDOWN_LOAD;
`else
            state     <= ST_IDLE;
`endif
          end else begin
            smash_cnt <= smash_cnt - SM_W'(1);
          end
        end
`ifdef SMASH_COOLDOWN_EN
        ST_COOLDOWN: begin
          // A press seen on the final cooldown cycle is dropped, not queued.
          if (smash_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            smash_cnt <= smash_cnt - SM_W'(1);
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          smash_cnt <= '0;
        end
      endcase
    end
  end

  assign btn_level    = stable[3:0];
  assign sw_level     = stable[7:4];
  assign smash_active = (state == ST_ACTIVE);
  assign smash_ready  = (state == ST_IDLE);

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner: directed scenarios plus randomized inputs checked
// against a window-based debounce model and an interval-based smash model.
module tb_btn_conditioner;

  localparam int D = 4;
  localparam int S = 3;
  localparam int C = 5;
`ifdef SMASH_COOLDOWN_EN
  localparam int BUSY = S + C;
`else
  localparam int BUSY = S;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] usr_btn_raw = '0;
  logic [3:0] usr_sw_raw = '0;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] sw_level;
  logic       smash_active;
  logic       smash_ready;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .SMASH_LEN(S),
    .COOLDOWN_LEN(C)
  ) dut (
    .clk(clk),
    .reset(reset),
    .usr_btn_raw(usr_btn_raw),
    .usr_sw_raw(usr_sw_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .sw_level(sw_level),
    .smash_active(smash_active),
    .smash_ready(smash_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: raw samples per edge, last D synchronized samples,
  // accepted levels, and the smash window / ready-again cycle numbers.
  logic [7:0] hist[$];
  logic [7:0] sq[$];
  logic [7:0] m_stable;
  logic [3:0] m_press;
  int         m_ws;
  int         m_ready_at;

  function automatic void model_reset();
    hist.delete();
    sq.delete();
    m_stable   = '0;
    m_press    = '0;
    m_ws       = -1000;
    m_ready_at = 0;
  endfunction

  // Advance one clock edge, update the model, and return at the falling edge.
  task automatic tick();
    logic [7:0] raw;
    logic [7:0] synced;
    logic       all_diff;
    @(posedge clk);
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      raw    = {usr_sw_raw, usr_btn_raw};
      synced = (hist.size() >= 2) ? hist[hist.size()-2] : 8'h00;
      hist.push_back(raw);
      if (hist.size() > 4) void'(hist.pop_front());
      sq.push_back(synced);
      if (sq.size() > D) void'(sq.pop_front());
      // Press seen during the previous cycle is accepted only if the FSM was idle then.
      if (m_press[3] && (cyc - 1) >= m_ready_at) begin
        m_ws       = cyc;
        m_ready_at = cyc + BUSY;
      end
      m_press = '0;
      if (sq.size() == D) begin
        for (int i = 0; i < 8; i++) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) begin
            if (sq[j][i] == m_stable[i]) all_diff = 1'b0;
          end
          if (all_diff) begin
            m_stable[i] = ~m_stable[i];
            if (i < 4 && m_stable[i]) m_press[i] = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    usr_btn_raw = '0;
    usr_sw_raw  = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    usr_btn_raw = 4'($urandom);
    usr_sw_raw  = 4'($urandom);
    #1;
    checks++; if (btn_level !== 4'h0) begin errors++; $display("FAIL reset_btn_level got=%h exp=0", btn_level); end
    checks++; if (btn_press !== 4'h0) begin errors++; $display("FAIL reset_btn_press got=%h exp=0", btn_press); end
    checks++; if (sw_level !== 4'h0) begin errors++; $display("FAIL reset_sw_level got=%h exp=0", sw_level); end
    checks++; if (smash_active !== 1'b0) begin errors++; $display("FAIL reset_smash_active got=%b exp=0", smash_active); end
    checks++; if (smash_ready !== 1'b1) begin errors++; $display("FAIL reset_smash_ready got=%b exp=1", smash_ready); end
    tick();
    tick();
    usr_btn_raw = '0;
    usr_sw_raw  = '0;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({btn_level, sw_level, btn_press} !== 12'h000 || smash_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle cyc=%0d got=%h/%b exp=000/1", cyc, {btn_level, sw_level, btn_press}, smash_ready);
      end
    end
  endtask

  task automatic test_clean_edge();
    usr_btn_raw[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (btn_level[0] !== (k >= 6)) begin
        errors++;
        $display("FAIL clean_edge_level k=%0d got=%b exp=%b", k, btn_level[0], (k >= 6));
      end
      checks++;
      if (btn_press[0] !== (k == 6)) begin
        errors++;
        $display("FAIL clean_edge_press k=%0d got=%b exp=%b", k, btn_press[0], (k == 6));
      end
    end
    quiet(10);
  endtask

  task automatic test_bounce();
    logic [3:0] pattern;
    int         presses;
    pattern = 4'b0101;
    presses = 0;
    for (int k = 0; k < 4; k++) begin
      usr_btn_raw[1] = pattern[k];
      tick();
    end
    usr_btn_raw[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (btn_press[1] === 1'b1) presses++;
      checks++;
      if (btn_level[1] !== (k >= 6) || btn_press[1] !== (k == 6)) begin
        errors++;
        $display("FAIL bounce k=%0d got=%b%b exp=%b%b", k, btn_level[1], btn_press[1], (k >= 6), (k == 6));
      end
    end
    checks++;
    if (presses != 1) begin errors++; $display("FAIL bounce_press_count got=%0d exp=1", presses); end
    quiet(10);
  endtask

  // Raw high 4, low 4, high 4: presses land at T and T+8 (T = raw rise + 6).
  task automatic test_smash();
    int  t;
    int  rel;
    logic exp_act;
    logic exp_rdy;
    t = cyc + 6;
    for (int k = 0; k < 24; k++) begin
      usr_btn_raw[3] = (k < 4) || (k >= 8 && k < 12);
      tick();
      rel = cyc - t;
`ifdef SMASH_COOLDOWN_EN
      exp_act = (rel >= 1 && rel <= 3);
      exp_rdy = !(rel >= 1 && rel <= 8);
`else
      exp_act = (rel >= 1 && rel <= 3) || (rel >= 9 && rel <= 11);
      exp_rdy = !exp_act;
`endif
      checks++;
      if (btn_press[3] !== (rel == 0 || rel == 8)) begin
        errors++;
        $display("FAIL smash_press rel=%0d got=%b", rel, btn_press[3]);
      end
      checks++;
      if (smash_active !== exp_act || smash_ready !== exp_rdy) begin
        errors++;
        $display("FAIL smash_window rel=%0d got=%b%b exp=%b%b", rel, smash_active, smash_ready, exp_act, exp_rdy);
      end
    end
    quiet(12);
  endtask

  task automatic test_reset_mid_window();
    usr_btn_raw[3] = 1'b1;
    usr_sw_raw[2]  = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (smash_active !== 1'b1) begin errors++; $display("FAIL mid_window_pre got=%b exp=1", smash_active); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (smash_active !== 1'b0 || smash_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_window_async got=%b%b exp=01", smash_active, smash_ready);
    end
    checks++;
    if ({btn_level, sw_level, btn_press} !== 12'h000) begin
      errors++;
      $display("FAIL mid_window_levels got=%h exp=000", {btn_level, sw_level, btn_press});
    end
    @(negedge clk);
    usr_btn_raw = '0;
    usr_sw_raw  = '0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (smash_active !== 1'b0 || btn_press !== 4'h0 || btn_level !== 4'h0) begin
        errors++;
        $display("FAIL mid_window_after k=%0d got=%b/%h/%h", k, smash_active, btn_press, btn_level);
      end
    end
  endtask

  task automatic test_switch_reset();
    usr_sw_raw[0] = 1'b1;
    #2 reset = 1'b1;
    model_reset();
    @(negedge clk);
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (sw_level[0] !== (k >= 6)) begin
        errors++;
        $display("FAIL switch_release k=%0d got=%b exp=%b", k, sw_level[0], (k >= 6));
      end
    end
  endtask

  task automatic test_random();
    int         hold[8];
    logic [7:0] cur;
    logic       exp_act;
    logic       exp_rdy;
    cur = {usr_sw_raw, usr_btn_raw};
    for (int b = 0; b < 8; b++) hold[b] = 0;
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 8; b++) begin
        if (hold[b] == 0) begin
          cur[b]  = 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 9);
        end
        hold[b]--;
      end
      usr_btn_raw = cur[3:0];
      usr_sw_raw  = cur[7:4];
      tick();
      exp_act = (cyc >= m_ws) && (cyc < m_ws + S);
      exp_rdy = (cyc >= m_ready_at);
      checks++;
      if ({sw_level, btn_level} !== m_stable) begin
        errors++;
        $display("FAIL rand_levels cyc=%0d got=%h exp=%h", cyc, {sw_level, btn_level}, m_stable);
      end
      checks++;
      if (btn_press !== m_press) begin
        errors++;
        $display("FAIL rand_press cyc=%0d got=%h exp=%h", cyc, btn_press, m_press);
      end
      checks++;
      if (smash_active !== exp_act || smash_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rand_smash cyc=%0d got=%b%b exp=%b%b", cyc, smash_active, smash_ready, exp_act, exp_rdy);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_edge();
    test_bounce();
    test_smash();
    test_reset_mid_window();
    test_switch_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
